// File: rtl/store_buffer_if.sv
// Handshake bundle for the store buffer: commit push, d-cache drain,
// load forwarding probe and status flags.
interface store_buffer_if;
  logic        store_en;
  logic        store_isbyte;
  logic [19:0] store_addr;
  logic [31:0] store_data;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        drain_valid;
  logic        drain_ready;
  logic [19:0] drain_addr;
  logic [31:0] drain_data;
  logic        drain_isbyte;
  logic        lookup_en;
  logic [19:0] lookup_addr;
  logic        lookup_isbyte;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        lookup_stall;

  modport master (
    output store_en, store_isbyte, store_addr, store_data,
    output drain_ready, lookup_en, lookup_addr, lookup_isbyte,
    input  full, empty, overflow, drain_valid, drain_addr, drain_data,
    input  drain_isbyte, lookup_hit, lookup_data, lookup_stall
  );

  modport slave (
    input  store_en, store_isbyte, store_addr, store_data,
    input  drain_ready, lookup_en, lookup_addr, lookup_isbyte,
    output full, empty, overflow, drain_valid, drain_addr, drain_data,
    output drain_isbyte, lookup_hit, lookup_data, lookup_stall
  );
endinterface

// File: rtl/store_buffer.sv
// In-order committed-store FIFO draining to the d-cache, with same-cycle
// store-to-load forwarding from the youngest matching entry.
module store_buffer #(
  parameter int n_entries = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(n_entries);

  logic [19:0]      r_addr   [n_entries];
  logic [31:0]      r_data   [n_entries];
  logic             r_isbyte [n_entries];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_sel;
  logic [31:0]      w_shifted;

  assign w_full  = (r_count == (PTR_W+1)'(n_entries));
  assign w_empty = (r_count == '0);
  assign w_push  = sb.store_en && !w_full;
  assign w_pop   = !w_empty && sb.drain_ready;

  assign sb.full         = w_full;
  assign sb.empty        = w_empty;
  assign sb.overflow     = r_overflow;
  assign sb.drain_valid  = !w_empty;
  // Stale entries stay in storage after reset, so gate the head view.
  assign sb.drain_addr   = w_empty ? 20'h0 : r_addr[r_head];
  assign sb.drain_data   = w_empty ? 32'h0 : r_data[r_head];
  assign sb.drain_isbyte = w_empty ? 1'b0  : r_isbyte[r_head];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (sb.store_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Byte stores are held zero-extended so the drain path needs no masking.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_addr[r_tail]   <= sb.store_addr;
      r_data[r_tail]   <= sb.store_isbyte ? {24'h0, sb.store_data[7:0]} : sb.store_data;
      r_isbyte[r_tail] <= sb.store_isbyte;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < n_entries; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (sb.lookup_en && ((PTR_W+1)'(i) < r_count) &&
          (r_addr[w_idx][19:2] == sb.lookup_addr[19:2])) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_shifted = r_data[w_sel] >> {sb.lookup_addr[1:0], 3'b000};

  always_comb begin
    sb.lookup_hit   = 1'b0;
    sb.lookup_stall = 1'b0;
    sb.lookup_data  = 32'h0;
    if (w_found) begin
      if (!sb.lookup_isbyte) begin
        if (r_isbyte[w_sel]) begin
          sb.lookup_stall = 1'b1;
        end else begin
          sb.lookup_hit  = 1'b1;
          sb.lookup_data = r_data[w_sel];
        end
      end else if (!r_isbyte[w_sel]) begin
        sb.lookup_hit  = 1'b1;
        sb.lookup_data = {24'h0, w_shifted[7:0]};
      end else if (r_addr[w_sel][1:0] == sb.lookup_addr[1:0]) begin
        sb.lookup_hit  = 1'b1;
        sb.lookup_data = {24'h0, r_data[w_sel][7:0]};
      end else begin
        sb.lookup_stall = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: FIFO ordering, full/overflow, wrap,
// forwarding cases and reset with live entries.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  store_buffer_if sb_if ();
  store_buffer #(.n_entries(4)) dut (.i_clk(clk), .i_rst(rst), .sb(sb_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [19:0] a, input logic [31:0] d, input logic b);
    sb_if.store_en = 1'b1; sb_if.store_addr = a; sb_if.store_data = d; sb_if.store_isbyte = b;
    tick();
    sb_if.store_en = 1'b0;
  endtask

  task automatic probe(input logic [19:0] a, input logic b);
    sb_if.lookup_en = 1'b1; sb_if.lookup_addr = a; sb_if.lookup_isbyte = b;
    #1;
  endtask

  task automatic do_reset();
    sb_if.store_en = 0; sb_if.drain_ready = 0; sb_if.lookup_en = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    sb_if.store_addr = 0; sb_if.store_data = 0; sb_if.store_isbyte = 0;
    sb_if.lookup_addr = 0; sb_if.lookup_isbyte = 0;
    do_reset();
    probe(20'h0, 1'b0);
    total++; if (sb_if.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", sb_if.empty); end
    total++; if (sb_if.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", sb_if.full); end
    total++; if (sb_if.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", sb_if.overflow); end
    total++; if ({sb_if.drain_valid, sb_if.drain_addr, sb_if.drain_data, sb_if.drain_isbyte} !== 54'h0) begin
      bad++; $display("FAIL reset_drain got v=%b a=%h d=%h", sb_if.drain_valid, sb_if.drain_addr, sb_if.drain_data); end
    total++; if ({sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data} !== 34'h0) begin
      bad++; $display("FAIL reset_lookup got h=%b s=%b d=%h", sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data); end
    sb_if.lookup_en = 0;
  endtask

  task automatic test_fifo_order();
    logic [19:0] ea [3] = '{20'h100, 20'h104, 20'h108};
    logic [31:0] ed [3] = '{32'hA, 32'hB, 32'hC};
    do_reset();
    for (int i = 0; i < 3; i++) push(ea[i], ed[i], 1'b0);
    total++; if (sb_if.drain_valid !== 1'b1 || sb_if.drain_addr !== 20'h100) begin
      bad++; $display("FAIL order_head got v=%b a=%h exp v=1 a=00100", sb_if.drain_valid, sb_if.drain_addr); end
    tick();
    total++; if (sb_if.drain_addr !== 20'h100 || sb_if.empty !== 1'b0 || sb_if.full !== 1'b0) begin
      bad++; $display("FAIL order_stable got a=%h e=%b f=%b", sb_if.drain_addr, sb_if.empty, sb_if.full); end
    sb_if.drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (sb_if.drain_valid !== 1'b1 || sb_if.drain_addr !== ea[i] || sb_if.drain_data !== ed[i]) begin
        bad++; $display("FAIL order_drain%0d got a=%h d=%h exp a=%h d=%h", i, sb_if.drain_addr, sb_if.drain_data, ea[i], ed[i]); end
      tick();
    end
    sb_if.drain_ready = 1'b0;
    total++; if (sb_if.empty !== 1'b1 || sb_if.drain_valid !== 1'b0) begin
      bad++; $display("FAIL order_empty got e=%b v=%b exp e=1 v=0", sb_if.empty, sb_if.drain_valid); end
  endtask

  task automatic test_full_wrap();
    logic [19:0] ea [4] = '{20'h14, 20'h18, 20'h1C, 20'h20};
    do_reset();
    push(20'h10, 32'h1, 0); push(20'h14, 32'h2, 0); push(20'h18, 32'h3, 0);
    // push and pop together at count 3: tail wraps 3 -> 0
    sb_if.drain_ready = 1'b1;
    push(20'h1C, 32'h4, 0);
    sb_if.drain_ready = 1'b0;
    total++; if (sb_if.full !== 1'b0 || sb_if.drain_addr !== 20'h14) begin
      bad++; $display("FAIL pushpop got f=%b a=%h exp f=0 a=00014", sb_if.full, sb_if.drain_addr); end
    push(20'h20, 32'h5, 0);
    total++; if (sb_if.full !== 1'b1 || sb_if.overflow !== 1'b0) begin
      bad++; $display("FAIL full got f=%b o=%b exp f=1 o=0", sb_if.full, sb_if.overflow); end
    sb_if.drain_ready = 1'b1;
    push(20'h24, 32'h6, 0);
    total++; if (sb_if.full !== 1'b0 || sb_if.overflow !== 1'b1) begin
      bad++; $display("FAIL overflow got f=%b o=%b exp f=0 o=1", sb_if.full, sb_if.overflow); end
    for (int i = 1; i < 4; i++) begin
      total++; if (sb_if.drain_valid !== 1'b1 || sb_if.drain_addr !== ea[i]) begin
        bad++; $display("FAIL wrap_drain%0d got v=%b a=%h exp a=%h", i, sb_if.drain_valid, sb_if.drain_addr, ea[i]); end
      tick();
    end
    sb_if.drain_ready = 1'b0;
    total++; if (sb_if.empty !== 1'b1 || sb_if.overflow !== 1'b1) begin
      bad++; $display("FAIL wrap_end got e=%b o=%b exp e=1 o=1", sb_if.empty, sb_if.overflow); end
  endtask

  task automatic test_fwd_word();
    do_reset();
    push(20'h200, 32'h11223344, 0);
    probe(20'h202, 1'b1);
    total++; if (sb_if.lookup_hit !== 1'b1 || sb_if.lookup_stall !== 1'b0 || sb_if.lookup_data !== 32'h22) begin
      bad++; $display("FAIL fwd_byte202 got h=%b s=%b d=%h exp h=1 s=0 d=00000022", sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data); end
    probe(20'h203, 1'b1);
    total++; if (sb_if.lookup_hit !== 1'b1 || sb_if.lookup_data !== 32'h11) begin
      bad++; $display("FAIL fwd_byte203 got h=%b d=%h exp h=1 d=00000011", sb_if.lookup_hit, sb_if.lookup_data); end
    probe(20'h200, 1'b0);
    total++; if (sb_if.lookup_hit !== 1'b1 || sb_if.lookup_data !== 32'h11223344) begin
      bad++; $display("FAIL fwd_word got h=%b d=%h exp h=1 d=11223344", sb_if.lookup_hit, sb_if.lookup_data); end
    probe(20'h204, 1'b0);
    total++; if ({sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data} !== 34'h0) begin
      bad++; $display("FAIL fwd_miss got h=%b s=%b d=%h exp all 0", sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data); end
    sb_if.lookup_en = 0;
  endtask

  task automatic test_fwd_byte();
    do_reset();
    push(20'h301, 32'hFFFFFFEE, 1);
    total++; if (sb_if.drain_data !== 32'hEE || sb_if.drain_isbyte !== 1'b1) begin
      bad++; $display("FAIL byte_drain got d=%h b=%b exp d=000000ee b=1", sb_if.drain_data, sb_if.drain_isbyte); end
    probe(20'h300, 1'b0);
    total++; if (sb_if.lookup_stall !== 1'b1 || sb_if.lookup_hit !== 1'b0 || sb_if.lookup_data !== 32'h0) begin
      bad++; $display("FAIL stall_word got h=%b s=%b d=%h exp h=0 s=1", sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data); end
    probe(20'h300, 1'b1);
    total++; if (sb_if.lookup_stall !== 1'b1 || sb_if.lookup_hit !== 1'b0) begin
      bad++; $display("FAIL stall_byte got h=%b s=%b exp h=0 s=1", sb_if.lookup_hit, sb_if.lookup_stall); end
    probe(20'h301, 1'b1);
    total++; if (sb_if.lookup_hit !== 1'b1 || sb_if.lookup_stall !== 1'b0 || sb_if.lookup_data !== 32'hEE) begin
      bad++; $display("FAIL byte_hit got h=%b s=%b d=%h exp h=1 d=000000ee", sb_if.lookup_hit, sb_if.lookup_stall, sb_if.lookup_data); end
    sb_if.lookup_en = 1'b0;
    #1;
    total++; if (sb_if.lookup_hit !== 1'b0 || sb_if.lookup_data !== 32'h0) begin
      bad++; $display("FAIL lookup_off got h=%b d=%h exp 0", sb_if.lookup_hit, sb_if.lookup_data); end
  endtask

  task automatic test_youngest();
    do_reset();
    push(20'h400, 32'h1, 0); push(20'h400, 32'h2, 0);
    probe(20'h400, 1'b0);
    total++; if (sb_if.lookup_hit !== 1'b1 || sb_if.lookup_data !== 32'h2) begin
      bad++; $display("FAIL youngest got h=%b d=%h exp d=00000002", sb_if.lookup_hit, sb_if.lookup_data); end
    sb_if.store_en = 1; sb_if.store_addr = 20'h400; sb_if.store_data = 32'h3; sb_if.store_isbyte = 0;
    #1;
    total++; if (sb_if.lookup_data !== 32'h2) begin
      bad++; $display("FAIL samecycle_push got d=%h exp d=00000002", sb_if.lookup_data); end
    tick();
    sb_if.store_en = 0;
    #1;
    total++; if (sb_if.lookup_data !== 32'h3) begin
      bad++; $display("FAIL after_push got d=%h exp d=00000003", sb_if.lookup_data); end
    sb_if.lookup_en = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push(20'h500 + 20'(4*i), 32'(i), 0);
    sb_if.drain_ready = 1'b1;
    tick(); tick();
    sb_if.drain_ready = 1'b0;
    total++; if (sb_if.overflow !== 1'b1 || sb_if.drain_addr !== 20'h508) begin
      bad++; $display("FAIL pre_rst got o=%b a=%h exp o=1 a=00508", sb_if.overflow, sb_if.drain_addr); end
    sb_if.drain_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_if.drain_ready = 1'b0;
    #1;
    total++; if (sb_if.empty !== 1'b1 || sb_if.drain_valid !== 1'b0 || sb_if.overflow !== 1'b0) begin
      bad++; $display("FAIL mid_rst got e=%b v=%b o=%b exp e=1 v=0 o=0", sb_if.empty, sb_if.drain_valid, sb_if.overflow); end
    push(20'h600, 32'h77, 0);
    total++; if (sb_if.drain_addr !== 20'h600 || sb_if.drain_data !== 32'h77 || sb_if.full !== 1'b0) begin
      bad++; $display("FAIL post_rst got a=%h d=%h f=%b exp a=00600 d=00000077", sb_if.drain_addr, sb_if.drain_data, sb_if.full); end
  endtask

  initial begin
    rst = 1'b1;
    sb_if.store_en = 0; sb_if.drain_ready = 0; sb_if.lookup_en = 0;
    test_reset();
    test_fifo_order();
    test_full_wrap();
    test_fwd_word();
    test_fwd_byte();
    test_youngest();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
